vga_tile_capture: RTL and testbench

- Receive-side monitor for the 640x480 VGA stream driven by the game's VGA controller: samples hsync/vsync/RGB on a pixel strobe, checks frame timing, and captures the colour at the centre of each of the 16 tiles of the 4x4 board.
- Captured colours are double-buffered and committed only for frames whose timing is correct. A tile-select readout port feeds bench checkers and an on-board self-test.

---
 rtl/vga_tile_capture.sv | 210 +++++++++++++++++++++
 tb/tb_vga_tile_capture.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_capture.sv
// vga_tile_capture
//   Receive-side monitor for a 640x480 VGA stream. Samples hsync/vsync/RGB on
//   each pixel strobe, measures line and frame lengths, and captures the colour
//   at the centre of each tile of a 4x4 board. Captures land in a shadow grid
//   and are copied to the committed grid only when the frame timing is good.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   pix_en              pixel strobe; stream inputs sampled only when high
//   hsync, vsync        active-low syncs
//   red, green, blue    pixel colour
//   tile_sel            readout index, row*4+col
//   tile_rgb            committed {r,g,b} of tile_sel, one clk latency
//   frame_valid         one-clk pulse per committed frame
//   locked              LOCK_FRAMES consecutive good frames seen
//   err_count           saturating count of bad frames
//   h_len, v_len        last measured line / frame length
//
// state   | meaning
// SEARCH  | waiting for the first vsync fall; stream ignored
// ACQUIRE | sampling tiles, fewer than LOCK_FRAMES good frames in a row
// LOCKED  | sampling tiles, LOCK_FRAMES good frames in a row

module vga_tile_capture #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_VIS_START = 144,
  parameter int V_VIS_START = 35,
  parameter int GRID_X0     = 80,
  parameter int GRID_Y0     = 0,
  parameter int TILE_PITCH  = 120,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  input  logic [3:0]  tile_sel,
  output logic [23:0] tile_rgb,
  output logic        frame_valid,
  output logic        locked,
  output logic [7:0]  err_count,
  output logic [10:0] h_len,
  output logic [9:0]  v_len
);

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [7:0]  LOCK_W    = 8'(LOCK_FRAMES);

  state_t      state_q, state_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [10:0] hcnt_q, hcnt_d, h_len_q, h_len_d;
  logic [9:0]  vcnt_q, vcnt_d, v_len_q, v_len_d;
  logic        bad_q, bad_d, exempt_q, exempt_d, fv_q, fv_d;
  logic [7:0]  good_q, good_d, err_q, err_d;
  logic [23:0] tile_rgb_q, tile_rgb_d;
  logic [23:0] shadow_q [16];
  logic [23:0] shadow_d [16];
  logic [23:0] grid_q [16];
  logic [23:0] grid_d [16];

  logic        h_fall, v_fall, line_bad, frame_good, eval, commit;
  logic [10:0] line_len;
  logic [9:0]  frame_len;
  logic [7:0]  good_inc;

  assign h_fall    = pix_en & hs_prev_q & ~hsync;
  assign v_fall    = pix_en & vs_prev_q & ~vsync;
  assign line_len  = hcnt_q + 11'd1;
  // When both syncs fall together the line that just ended still belongs
  // to the finishing frame, so count it.
  assign frame_len = h_fall ? vcnt_q + 10'd1 : vcnt_q;
  assign line_bad  = h_fall && (line_len != H_TOTAL_W) && !exempt_q && (state_q != SEARCH);
  assign frame_good = !bad_q && !line_bad && (frame_len == V_TOTAL_W);
  assign eval      = v_fall && (state_q != SEARCH);
  assign commit    = eval && frame_good;
  assign good_inc  = (good_q >= LOCK_W - 8'd1) ? LOCK_W : good_q + 8'd1;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= SEARCH;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (v_fall) state_d = ACQUIRE;
      ACQUIRE, LOCKED: begin
        if (commit && good_inc == LOCK_W) state_d = LOCKED;
        else if (eval && !frame_good)     state_d = ACQUIRE;
      end
      default: state_d = SEARCH;
    endcase
  end

  // outputs
  always_comb begin
    locked      = (state_q == LOCKED);
    frame_valid = fv_q;
    tile_rgb    = tile_rgb_q;
    err_count   = err_q;
    h_len       = h_len_q;
    v_len       = v_len_q;
  end

  // datapath
  always_comb begin
    hs_prev_d  = hs_prev_q;
    vs_prev_d  = vs_prev_q;
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    h_len_d    = h_len_q;
    v_len_d    = v_len_q;
    bad_d      = bad_q;
    exempt_d   = exempt_q;
    good_d     = good_q;
    err_d      = err_q;
    fv_d       = 1'b0;
    shadow_d   = shadow_q;
    grid_d     = grid_q;
    tile_rgb_d = grid_q[tile_sel];

    // The line measured from reset or from SEARCH is arbitrary, so skip it.
    if (state_q == SEARCH) exempt_d = 1'b1;
    else if (h_fall)       exempt_d = 1'b0;

    if (pix_en) begin
      hs_prev_d = hsync;
      vs_prev_d = vsync;
      if (h_fall)                hcnt_d = 11'd0;
      else if (hcnt_q != 11'h7FF) hcnt_d = hcnt_q + 11'd1;
      if (v_fall)                                vcnt_d = 10'd0;
      else if (h_fall && vcnt_q != 10'h3FF)      vcnt_d = vcnt_q + 10'd1;
      if (h_fall) h_len_d = line_len;
      if (v_fall) v_len_d = frame_len;
    end

    if (v_fall)        bad_d = 1'b0;
    else if (line_bad) bad_d = 1'b1;

    if (state_q == SEARCH && v_fall) begin
      for (int i = 0; i < 16; i++) shadow_d[i] = 24'd0;
    end

    // Position checks use the post-update counts, i.e. the index of the
    // pixel being sampled right now (0 on the sync-fall pixel).
    if (pix_en && state_q != SEARCH) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (hcnt_d == 11'(H_VIS_START + GRID_X0 + c*TILE_PITCH + TILE_PITCH/2) &&
              vcnt_d == 10'(V_VIS_START + GRID_Y0 + r*TILE_PITCH + TILE_PITCH/2))
            shadow_d[r*4+c] = {red, green, blue};
        end
      end
    end

    if (commit) begin
      grid_d = shadow_q;
      good_d = good_inc;
      fv_d   = 1'b1;
    end else if (eval) begin
      good_d = 8'd0;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev_q  <= 1'b1;
      vs_prev_q  <= 1'b1;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      h_len_q    <= '0;
      v_len_q    <= '0;
      bad_q      <= 1'b0;
      exempt_q   <= 1'b0;
      good_q     <= '0;
      err_q      <= '0;
      fv_q       <= 1'b0;
      tile_rgb_q <= '0;
      shadow_q   <= '{default: '0};
      grid_q     <= '{default: '0};
    end else begin
      hs_prev_q  <= hs_prev_d;
      vs_prev_q  <= vs_prev_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      h_len_q    <= h_len_d;
      v_len_q    <= v_len_d;
      bad_q      <= bad_d;
      exempt_q   <= exempt_d;
      good_q     <= good_d;
      err_q      <= err_d;
      fv_q       <= fv_d;
      tile_rgb_q <= tile_rgb_d;
      shadow_q   <= shadow_d;
      grid_q     <= grid_d;
    end
  end

endmodule

// File: tb/tb_vga_tile_capture.sv
// tb_vga_tile_capture
//   Directed bench for vga_tile_capture. The DUT runs with a scaled-down
//   timing (40 pixels x 20 lines, 4-pixel tiles) so each frame is short;
//   every relationship between the parameters is preserved.
//   Ports: none (self-contained, prints one summary line).

module tb_vga_tile_capture;

  localparam int HT = 40, VT = 20, HVS = 8, VVS = 2, GX0 = 2, GY0 = 0, TP = 4, LF = 2;

  logic        clk = 1'b0;
  logic        rst, pix_en, hsync, vsync;
  logic [7:0]  red, green, blue;
  logic [3:0]  tile_sel;
  logic [23:0] tile_rgb;
  logic        frame_valid, locked;
  logic [7:0]  err_count;
  logic [10:0] h_len;
  logic [9:0]  v_len;

  int n_vec = 0, n_err = 0, fv_cnt = 0;
  bit opened = 1'b0;

  vga_tile_capture #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_VIS_START(HVS), .V_VIS_START(VVS),
    .GRID_X0(GX0), .GRID_Y0(GY0), .TILE_PITCH(TP), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .tile_sel(tile_sel),
    .tile_rgb(tile_rgb), .frame_valid(frame_valid), .locked(locked),
    .err_count(err_count), .h_len(h_len), .v_len(v_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_valid === 1'b1) fv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tile centre for line L, pixel p (p counted from the hsync-fall pixel).
  function automatic logic [23:0] pix_colour(input int L, input int p, input logic [23:0] mult);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (p == HVS + GX0 + c*TP + TP/2 && L == VVS + GY0 + r*TP + TP/2)
          return 24'(mult * 24'(r*4 + c));
    return 24'hA5A5A5 ^ {8'(p), 8'(L), 8'h3C};
  endfunction

  task automatic pix(input logic hs, input logic vs, input logic [23:0] rgb);
    @(negedge clk);
    pix_en = 1'b1; hsync = hs; vsync = vs; {red, green, blue} = rgb;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic send_lines(input int first, input int last, input int short_line,
                            input logic [23:0] mult);
    for (int L = first; L <= last; L++) begin
      int len;
      len = (L == short_line) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        if (L == 0 && p == 0 && opened) begin
          opened = 1'b0;
          continue;
        end
        pix(p >= 4, L >= 2, pix_colour(L, p, mult));
      end
    end
  endtask

  // First pixel of the next frame: both syncs fall, which judges the frame.
  task automatic close_frame();
    pix(1'b0, 1'b0, 24'h0);
    opened = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input int nlines, input int short_line, input logic [23:0] mult);
    send_lines(0, nlines - 1, short_line, mult);
    close_frame();
  endtask

  task automatic rd(input logic [3:0] sel, input logic [23:0] exp, input string tag);
    @(negedge clk); tile_sel = sel;
    @(negedge clk); chk(tag, 32'(tile_rgb), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
    red = 8'd0; green = 8'd0; blue = 8'd0; tile_sel = 4'd5;
    repeat (3) @(negedge clk);
    chk("rst_tile_rgb", 32'(tile_rgb), 0);
    chk("rst_fv", 32'(frame_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_hlen", 32'(h_len), 0);
    chk("rst_vlen", 32'(v_len), 0);
    rst = 1'b0;

    // nominal frames
    frame(VT, -1, 24'h010101);
    chk("f1_fv", 32'(fv_cnt), 1);
    chk("f1_locked", 32'(locked), 0);
    frame(VT, -1, 24'h010101);
    chk("f2_fv", 32'(fv_cnt), 2);
    chk("f2_locked", 32'(locked), 1);
    frame(VT, -1, 24'h010101);
    chk("f3_fv", 32'(fv_cnt), 3);
    chk("f3_locked", 32'(locked), 1);
    chk("f3_err", 32'(err_count), 0);
    chk("f3_hlen", 32'(h_len), HT);
    chk("f3_vlen", 32'(v_len), VT);
    rd(4'd5, 24'h050505, "rd_tile5");
    rd(4'd0, 24'h000000, "rd_tile0");
    rd(4'd15, 24'h0F0F0F, "rd_tile15");
    rd(4'd6, 24'h060606, "rd_tile6");
    tile_sel = 4'd5;

    // short last line, new colours: frame rejected
    frame(VT, VT - 1, 24'h101010);
    chk("short_hlen", 32'(h_len), HT - 1);
    chk("short_err", 32'(err_count), 1);
    chk("short_locked", 32'(locked), 0);
    chk("short_fv", 32'(fv_cnt), 3);
    rd(4'd5, 24'h050505, "short_keep");
    frame(VT, -1, 24'h101010);
    chk("relock1_fv", 32'(fv_cnt), 4);
    chk("relock1_locked", 32'(locked), 0);
    frame(VT, -1, 24'h101010);
    chk("relock2_fv", 32'(fv_cnt), 5);
    chk("relock2_locked", 32'(locked), 1);
    rd(4'd5, 24'h505050, "relock_tile5");

    // one line short in the frame
    frame(VT - 1, -1, 24'h101010);
    chk("vshort_vlen", 32'(v_len), VT - 1);
    chk("vshort_err", 32'(err_count), 2);
    chk("vshort_fv", 32'(fv_cnt), 5);
    chk("vshort_locked", 32'(locked), 0);

    // reset mid-frame
    send_lines(0, 9, -1, 24'h010101);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mrst_tile_rgb", 32'(tile_rgb), 0);
    chk("mrst_fv", 32'(frame_valid), 0);
    chk("mrst_locked", 32'(locked), 0);
    chk("mrst_err", 32'(err_count), 0);
    chk("mrst_hlen", 32'(h_len), 0);
    chk("mrst_vlen", 32'(v_len), 0);
    send_lines(10, VT - 1, -1, 24'h010101);
    repeat (3) @(negedge clk);
    chk("mrst_search_fv", 32'(fv_cnt), 5);
    frame(VT, -1, 24'h020202);
    chk("mrst_first_fv", 32'(fv_cnt), 6);
    chk("mrst_first_locked", 32'(locked), 0);
    rd(4'd5, 24'h0A0A0A, "mrst_tile5");

    // garbage: a vsync fall every other pixel, no lines
    for (int i = 0; i < 255; i++) begin
      pix(1'b1, 1'b1, 24'h123456);
      pix(1'b1, 1'b0, 24'h654321);
    end
    repeat (3) @(negedge clk);
    chk("garb_err255", 32'(err_count), 255);
    for (int i = 0; i < 45; i++) begin
      pix(1'b1, 1'b1, 24'h123456);
      pix(1'b1, 1'b0, 24'h654321);
    end
    repeat (3) @(negedge clk);
    chk("garb_err_sat", 32'(err_count), 255);
    chk("garb_locked", 32'(locked), 0);
    chk("garb_fv", 32'(fv_cnt), 6);
    chk("garb_vlen", 32'(v_len), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
